pipe_hazard_ctrl: RTL and testbench

//  Parametrised stall/flush controller for the N-stage in-order pipeline (pc, if, id, ex, mem, wb by default).

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline.
// Merges per-stage stall requests into a prefix stall vector, derives the bubble vector,
// runs a timed flush sequence with a latched redirect PC, watches for stuck stalls and
// keeps stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned N_STAGES     = 6,
    parameter int unsigned PC_W         = 32,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDOG_CYCLES  = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_STAGES-1:0] stallreq_i,
    input  logic                flush_req_i,
    input  logic [PC_W-1:0]     flush_pc_i,
    output logic [N_STAGES-1:0] stall_o,
    output logic [N_STAGES-1:0] bubble_o,
    output logic                flush_o,
    output logic [PC_W-1:0]     new_pc_o,
    output logic [CNT_W-1:0]    stall_cnt_o,
    output logic [CNT_W-1:0]    flush_cnt_o,
    output logic                wdog_err_o,
    input  logic                wdog_clr_i
);

    localparam int unsigned FW = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned WW = $clog2(WDOG_CYCLES + 1);
    localparam logic [FW-1:0] FlushLoad = FW'(FLUSH_CYCLES);
    localparam logic [FW-1:0] FlushOne  = FW'(1);
    localparam logic [WW-1:0] WdogLimit = WW'(WDOG_CYCLES);
    localparam logic [WW-1:0] WdogOne   = WW'(1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic {StIdle, StFlush} state_e;

    state_e             state_q, state_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [WW-1:0]      wd_q, wd_d;
    logic               err_q, err_d;
    logic [N_STAGES-1:0] merged;

    // Prefix merge: stage k stalls if it or any later stage requests a stall.
    always_comb begin
        merged = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            merged[k] = |(stallreq_i >> k);
        end
    end

    // Stall only applies in IDLE; reset forces every output low even with live inputs.
    always_comb begin
        stall_o  = (state_q == StIdle && !rst) ? merged : '0;
        bubble_o = (stall_o << 1) & ~stall_o;
        flush_o  = (state_q == StFlush);
        new_pc_o = pc_q;
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
        wdog_err_o  = err_q;
    end

    // Flush FSM next state; a request in FLUSH relatches the PC and restarts the hold.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        pc_d    = pc_q;
        unique case (state_q)
            StIdle: begin
                if (flush_req_i) begin
                    state_d = StFlush;
                    fcnt_d  = FlushLoad;
                    pc_d    = flush_pc_i;
                end
            end
            StFlush: begin
                if (flush_req_i) begin
                    fcnt_d = FlushLoad;
                    pc_d   = flush_pc_i;
                end else if (fcnt_q == FlushOne) begin
                    state_d = StIdle;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FlushOne;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Performance counters and watchdog next state; clear beats a same-cycle set.
    always_comb begin
        stall_cnt_d = stall_o[0] ? stall_cnt_q + CntOne : stall_cnt_q;
        flush_cnt_d = flush_req_i ? flush_cnt_q + CntOne : flush_cnt_q;
        wd_d  = wd_q;
        err_d = err_q;
        if (wdog_clr_i) begin
            wd_d  = '0;
            err_d = 1'b0;
        end else if (stall_o != '0) begin
            wd_d  = (wd_q == WdogLimit) ? wd_q : wd_q + WdogOne;
            err_d = err_q | (wd_d == WdogLimit);
        end else begin
            wd_d = '0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            fcnt_q      <= '0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            wd_q        <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the driver pushes hand-computed expectations
// tagged with the cycle they belong to; the monitor pops and compares on the falling edge.
module tb_pipe_hazard_ctrl;

    localparam int F_STALL  = 0;
    localparam int F_BUB    = 1;
    localparam int F_FLUSH  = 2;
    localparam int F_PC     = 3;
    localparam int F_SCNT   = 4;
    localparam int F_FCNT   = 5;
    localparam int F_WD     = 6;
    localparam int F_FLUSH4 = 7;
    localparam int F_PC4    = 8;
    localparam int F_FCNT4  = 9;
    localparam int F_SCNT4  = 10;
    localparam int F_STALL4 = 11;
    localparam int F_BUB4   = 12;
    localparam int F_WD4    = 13;
    localparam int NF       = 14;

    logic        clk;
    logic        rst;
    logic [5:0]  stallreq;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic        wdog_clr;

    logic [5:0]  stall, bubble, stall4, bubble4;
    logic        flush, flush4, wd, wd4;
    logic [31:0] new_pc, new_pc4, scnt, scnt4, fcnt, fcnt4;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        int          fld;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    pipe_hazard_ctrl #(
        .N_STAGES(6), .PC_W(32), .CNT_W(32), .FLUSH_CYCLES(2), .WDOG_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .flush_req_i(flush_req),
        .flush_pc_i(flush_pc), .stall_o(stall), .bubble_o(bubble), .flush_o(flush),
        .new_pc_o(new_pc), .stall_cnt_o(scnt), .flush_cnt_o(fcnt), .wdog_err_o(wd),
        .wdog_clr_i(wdog_clr)
    );

    // Longer flush hold, used for the reset-mid-flush case.
    pipe_hazard_ctrl #(
        .N_STAGES(6), .PC_W(32), .CNT_W(32), .FLUSH_CYCLES(4), .WDOG_CYCLES(4)
    ) dut_f4 (
        .clk(clk), .rst(rst), .stallreq_i(stallreq), .flush_req_i(flush_req),
        .flush_pc_i(flush_pc), .stall_o(stall4), .bubble_o(bubble4), .flush_o(flush4),
        .new_pc_o(new_pc4), .stall_cnt_o(scnt4), .flush_cnt_o(fcnt4), .wdog_err_o(wd4),
        .wdog_clr_i(wdog_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int f);
        case (f)
            F_STALL:  return {26'd0, stall};
            F_BUB:    return {26'd0, bubble};
            F_FLUSH:  return {31'd0, flush};
            F_PC:     return new_pc;
            F_SCNT:   return scnt;
            F_FCNT:   return fcnt;
            F_WD:     return {31'd0, wd};
            F_FLUSH4: return {31'd0, flush4};
            F_PC4:    return new_pc4;
            F_FCNT4:  return fcnt4;
            F_SCNT4:  return scnt4;
            F_STALL4: return {26'd0, stall4};
            F_BUB4:   return {26'd0, bubble4};
            default:  return {31'd0, wd4};
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_STALL:  return "stall_o";
            F_BUB:    return "bubble_o";
            F_FLUSH:  return "flush_o";
            F_PC:     return "new_pc_o";
            F_SCNT:   return "stall_cnt_o";
            F_FCNT:   return "flush_cnt_o";
            F_WD:     return "wdog_err_o";
            F_FLUSH4: return "f4.flush_o";
            F_PC4:    return "f4.new_pc_o";
            F_FCNT4:  return "f4.flush_cnt_o";
            F_SCNT4:  return "f4.stall_cnt_o";
            F_STALL4: return "f4.stall_o";
            F_BUB4:   return "f4.bubble_o";
            default:  return "f4.wdog_err_o";
        endcase
    endfunction

    // Monitor: compare every expectation tagged with the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (e.cyc != cyc) begin
                    n_bad++;
                    $display("FAIL %s: check for cycle %0d seen at cycle %0d",
                             fname(e.fld), e.cyc, cyc);
                end else if (actual(e.fld) !== e.val) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d: got %h, expected %h",
                             fname(e.fld), cyc, actual(e.fld), e.val);
                end
            end
        end
    end

    task automatic drive(input logic [5:0] sr, input logic fr, input logic [31:0] pc,
                         input logic clr, input logic r);
        @(posedge clk);
        #1;
        stallreq  = sr;
        flush_req = fr;
        flush_pc  = pc;
        wdog_clr  = clr;
        rst       = r;
    endtask

    task automatic ex(input int f, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc;
        e.fld = f;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic ex_zero();
        for (int f = 0; f < NF; f++) ex(f, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stallreq = '0; flush_req = 1'b0; flush_pc = '0; wdog_clr = 1'b0;

        // Reset held with random inputs: every output low.
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'b1);
            ex_zero();
        end
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 0); ex(F_BUB, 0); ex(F_FLUSH, 0); ex(F_SCNT, 0); ex(F_FCNT, 0);

        // Stall merge, with an idle cycle so the watchdog stays quiet.
        drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b001111); ex(F_BUB, 6'b010000); ex(F_SCNT, 0);
        drive(6'b000110, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b000111); ex(F_BUB, 6'b001000); ex(F_SCNT, 1);
        drive(6'b100001, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b111111); ex(F_BUB, 6'b000000); ex(F_SCNT, 2);
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b000000); ex(F_BUB, 6'b000000); ex(F_SCNT, 3); ex(F_WD, 0);
        drive(6'b100000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b111111); ex(F_BUB, 6'b000000); ex(F_SCNT, 3);
        drive(6'b000001, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b000001); ex(F_BUB, 6'b000010); ex(F_SCNT, 4);
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_SCNT, 5); ex(F_WD, 0);

        // Flush over stall (FLUSH_CYCLES=2).
        drive(6'b000100, 1'b1, 32'hBFC00380, 1'b0, 1'b0);
        ex(F_STALL, 6'b000111); ex(F_BUB, 6'b001000); ex(F_FLUSH, 0); ex(F_PC, 0);
        ex(F_FCNT, 0); ex(F_SCNT, 5);
        for (int i = 0; i < 2; i++) begin
            drive(6'b000100, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_FLUSH, 1); ex(F_PC, 32'hBFC00380); ex(F_STALL, 0); ex(F_BUB, 0);
            ex(F_FCNT, 1); ex(F_SCNT, 6);
        end
        drive(6'b000100, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_FLUSH, 0); ex(F_STALL, 6'b000111); ex(F_BUB, 6'b001000);
        ex(F_PC, 32'hBFC00380); ex(F_FCNT, 1);

        // Back-to-back flush: second pulse in the first FLUSH cycle.
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        ex(F_FCNT, 0); ex(F_PC, 0); ex(F_FLUSH, 0);
        drive(6'b0, 1'b1, 32'h12345678, 1'b0, 1'b0);
        ex(F_FLUSH, 0); ex(F_FCNT, 0);
        drive(6'b0, 1'b1, 32'h80000000, 1'b0, 1'b0);
        ex(F_FLUSH, 1); ex(F_PC, 32'h12345678); ex(F_FCNT, 1);
        for (int i = 0; i < 2; i++) begin
            drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_FLUSH, 1); ex(F_PC, 32'h80000000); ex(F_FCNT, 2);
        end
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_FLUSH, 0); ex(F_PC, 32'h80000000); ex(F_FCNT, 2);

        // Watchdog (WDOG_CYCLES=4) with stallreq[3] held.
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        ex(F_WD, 0); ex(F_SCNT, 0);
        drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_STALL, 6'b001111); ex(F_WD, 0); ex(F_SCNT, 0);
        for (int i = 1; i <= 3; i++) begin
            drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_WD, 0); ex(F_SCNT, 32'(i));
        end
        drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_WD, 1); ex(F_SCNT, 4); ex(F_STALL, 6'b001111);
        drive(6'b001000, 1'b0, 32'h0, 1'b1, 1'b0);
        ex(F_WD, 1); ex(F_STALL, 6'b001111);
        for (int i = 0; i < 4; i++) begin
            drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_WD, 0);
        end
        drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_WD, 1);
        // Clear again, then clear on the edge that would set the error.
        drive(6'b001000, 1'b0, 32'h0, 1'b1, 1'b0);
        ex(F_WD, 1);
        for (int i = 0; i < 3; i++) begin
            drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_WD, 0);
        end
        drive(6'b001000, 1'b0, 32'h0, 1'b1, 1'b0);
        ex(F_WD, 0);
        drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_WD, 0);
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_WD, 0);
        // 3-cycle stalls separated by idle cycles never trip it.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 3; i++) drive(6'b001000, 1'b0, 32'h0, 1'b0, 1'b0);
            drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
            ex(F_WD, 0);
        end
        drive(6'b000000, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_WD, 0);

        // Reset in the second FLUSH cycle of the FLUSH_CYCLES=4 instance.
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        ex_zero();
        drive(6'b0, 1'b1, 32'hBFC00380, 1'b0, 1'b0);
        ex(F_FLUSH4, 0); ex(F_FCNT4, 0);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_FLUSH4, 1); ex(F_PC4, 32'hBFC00380); ex(F_FCNT4, 1); ex(F_STALL4, 0);
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        ex_zero();
        drive(6'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        ex(F_FLUSH4, 0); ex(F_PC4, 0); ex(F_FLUSH, 0); ex(F_FCNT4, 0);

        repeat (3) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: %0d expectations never checked", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
